// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, item codes and stock arithmetic for the dispenser
package vend_pkg;
   localparam int STOCK_W = 8;
   localparam logic STAR = 1'b0;
   localparam logic STRAITS = 1'b1;
   typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, COOL} state_t;
   // callers only decrement non-zero stock, so the sum never underflows
   function automatic logic [STOCK_W-1:0] sat_next(input logic [STOCK_W-1:0] s, input logic dec,
                                                   input logic [STOCK_W-1:0] add);
      logic [STOCK_W:0] sum;
      sum = {1'b0, s} - {{STOCK_W{1'b0}}, dec} + {1'b0, add};
      return sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
   endfunction
endpackage

// File: rtl/stock_counter.sv
// stock_counter: per-item stock with decrement and saturating refill in the same cycle
module stock_counter
   import vend_pkg::*;
#(
   parameter int INIT = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dec,
   input  logic               add,
   input  logic [STOCK_W-1:0] qty,
   output logic [STOCK_W-1:0] stock
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) stock <= STOCK_W'(INIT);
      else if (dec || add) stock <= sat_next(stock, dec, add ? qty : '0);
endmodule

// File: rtl/dispense_arbiter.sv
// dispense_arbiter: round-robin arbitration of two kiosks onto one feed motor with stock tracking
module dispense_arbiter
   import vend_pkg::*;
#(
   parameter int MOTOR_CYCLES = 4,
   parameter int COOL_CYCLES  = 2,
   parameter int STOCK_INIT   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] req_item,
   output logic [1:0] grant,
   output logic [1:0] done,
   output logic [1:0] nack,
   output logic       motor_en,
   output logic       motor_sel,
   input  logic       refill_valid,
   input  logic       refill_item,
   input  logic [7:0] refill_qty,
   output logic [1:0] empty
);
   localparam logic [15:0] MOT_LAST  = 16'(MOTOR_CYCLES - 1);
   localparam logic [15:0] COOL_LAST = 16'(COOL_CYCLES - 1);
   state_t state;
   logic win, item, rr, pick, sel_zero, dec;
   logic [15:0] cnt;
   logic [1:0] req_v, win_oh;
   logic [STOCK_W-1:0] star_stock, straits_stock;
   // a kiosk still seeing its done/nack pulse has not had a chance to drop req yet
   assign req_v    = req & ~nack & ~done;
   assign pick     = (req_v == 2'b11) ? rr : req_v[1];
   assign win_oh   = win ? 2'b10 : 2'b01;
   assign sel_zero = item ? (straits_stock == '0) : (star_stock == '0);
   assign dec      = (state == CHECK) && !sel_zero;
   assign empty    = {straits_stock == '0, star_stock == '0};
   stock_counter #(.INIT(STOCK_INIT)) u_star (
      .clk(clk), .rst(rst), .dec(dec && item == STAR),
      .add(refill_valid && refill_item == STAR), .qty(refill_qty), .stock(star_stock)
   );
   stock_counter #(.INIT(STOCK_INIT)) u_straits (
      .clk(clk), .rst(rst), .dec(dec && item == STRAITS),
      .add(refill_valid && refill_item == STRAITS), .qty(refill_qty), .stock(straits_stock)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         rr        <= 1'b0;
         win       <= 1'b0;
         item      <= STAR;
         cnt       <= '0;
         grant     <= '0;
         done      <= '0;
         nack      <= '0;
         motor_en  <= 1'b0;
         motor_sel <= STAR;
      end else begin
         done <= '0;
         nack <= '0;
         case (state)
            IDLE:
               if (|req_v) begin
                  win   <= pick;
                  item  <= req_item[pick];
                  state <= CHECK;
               end
            CHECK:
               if (sel_zero) begin
                  nack  <= win_oh;
                  rr    <= ~win;
                  state <= IDLE;
               end else begin
                  grant     <= win_oh;
                  motor_en  <= 1'b1;
                  motor_sel <= item;
                  cnt       <= '0;
                  state     <= DISPENSE;
               end
            DISPENSE:
               if (cnt == MOT_LAST) begin
                  grant    <= '0;
                  motor_en <= 1'b0;
                  done     <= win_oh;
                  rr       <= ~win;
                  cnt      <= '0;
                  state    <= (COOL_CYCLES == 0) ? IDLE : COOL;
               end else cnt <= cnt + 16'd1;
            COOL:
               if (cnt == COOL_LAST) state <= IDLE;
               else cnt <= cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dispense_arbiter.sv
// tb_dispense_arbiter: directed vectors with hand-computed expectations for dispense_arbiter
module tb_dispense_arbiter;
   import vend_pkg::*;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   logic [1:0] req = '0, req_item = '0, grant, done, nack, empty;
   logic refill_valid = 1'b0, refill_item = 1'b0, motor_en, motor_sel;
   logic [7:0] refill_qty = '0;
   logic [1:0] req_b = '0, req_item_b = '0, grant_b, done_b, nack_b, empty_b;
   logic refill_valid_b = 1'b0, refill_item_b = 1'b0, motor_en_b, motor_sel_b;
   logic [7:0] refill_qty_b = '0;
   int nvec = 0, nerr = 0;
   dispense_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .req_item(req_item), .grant(grant), .done(done),
      .nack(nack), .motor_en(motor_en), .motor_sel(motor_sel), .refill_valid(refill_valid),
      .refill_item(refill_item), .refill_qty(refill_qty), .empty(empty)
   );
   dispense_arbiter #(.STOCK_INIT(1)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .req_item(req_item_b), .grant(grant_b), .done(done_b),
      .nack(nack_b), .motor_en(motor_en_b), .motor_sel(motor_sel_b), .refill_valid(refill_valid_b),
      .refill_item(refill_item_b), .refill_qty(refill_qty_b), .empty(empty_b)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [1:0] eg;
      tick();
      check("rst_grant", 32'(grant), 0);
      check("rst_motor", 32'(motor_en), 0);
      check("rst_done_nack", 32'({done, nack}), 0);
      check("rst_empty", 32'(empty), 0);
      check("rst_star", 32'(dut.star_stock), 10);
      check("rst_straits", 32'(dut.straits_stock), 10);
      rst = 1'b1;
      // single star request from kiosk 0
      req = 2'b01;
      req_item = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("b_motor%0d", k), 32'(motor_en), 32'(k >= 2 && k <= 5));
         check($sformatf("b_grant%0d", k), 32'(grant), (k >= 2 && k <= 5) ? 1 : 0);
         check($sformatf("b_done%0d", k), 32'(done), (k == 6) ? 1 : 0);
         if (motor_en) check($sformatf("b_sel%0d", k), 32'(motor_sel), 0);
      end
      check("b_star", 32'(dut.star_stock), 9);
      req = 2'b00;
      tick();
      tick();
      // refill saturation
      refill_valid = 1'b1;
      refill_item = STAR;
      refill_qty = 8'd250;
      tick();
      check("c_star_sat", 32'(dut.star_stock), 255);
      refill_item = STRAITS;
      refill_qty = 8'd5;
      tick();
      refill_valid = 1'b0;
      check("c_straits", 32'(dut.straits_stock), 15);
      rst = 1'b0;
      #1;
      check("d_rst_star", 32'(dut.star_stock), 10);
      check("d_rst_straits", 32'(dut.straits_stock), 10);
      tick();
      rst = 1'b1;
      // both kiosks hold req, alternating grants
      req = 2'b11;
      req_item = 2'b10;
      for (int k = 1; k <= 22; k++) begin
         tick();
         eg = ((k >= 2 && k <= 5) || (k >= 18 && k <= 21)) ? 2'b01 : (k >= 10 && k <= 13) ? 2'b10 : 2'b00;
         check($sformatf("d_grant%0d", k), 32'(grant), 32'(eg));
         check($sformatf("d_motor%0d", k), 32'(motor_en), 32'(eg != 2'b00));
         check($sformatf("d_done%0d", k), 32'(done), (k == 6 || k == 22) ? 1 : (k == 14) ? 2 : 0);
         if (eg != 2'b00) check($sformatf("d_sel%0d", k), 32'(motor_sel), 32'(eg == 2'b10));
      end
      req = 2'b00;
      tick();
      tick();
      check("d_star", 32'(dut.star_stock), 8);
      check("d_straits", 32'(dut.straits_stock), 9);
      tick();
      // reset during the third motor cycle
      req = 2'b01;
      req_item = 2'b00;
      repeat (4) tick();
      check("f_motor_on", 32'(motor_en), 1);
      check("f_star_dec", 32'(dut.star_stock), 7);
      rst = 1'b0;
      #1;
      check("f_motor_async", 32'(motor_en), 0);
      check("f_grant_async", 32'(grant), 0);
      req = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      check("f_star", 32'(dut.star_stock), 10);
      check("f_straits", 32'(dut.straits_stock), 10);
      check("f_state", 32'(dut.state), 32'(IDLE));
      // req dropped in first dispense cycle
      req = 2'b01;
      req_item = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 2) req = 2'b00;
         check($sformatf("g_motor%0d", k), 32'(motor_en), 32'(k >= 2 && k <= 5));
         check($sformatf("g_done%0d", k), 32'(done), (k == 6) ? 1 : 0);
         if (motor_en) check($sformatf("g_sel%0d", k), 32'(motor_sel), 1);
      end
      check("g_straits", 32'(dut.straits_stock), 9);
      // STOCK_INIT = 1: second star request is refused
      req_b = 2'b01;
      req_item_b = 2'b00;
      repeat (6) tick();
      check("h_done", 32'(done_b), 1);
      req_b = 2'b00;
      check("h_empty", 32'(empty_b), 1);
      tick();
      tick();
      req_b = 2'b01;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("h_motor%0d", k), 32'(motor_en_b), 0);
         check($sformatf("h_nack%0d", k), 32'(nack_b), (k == 2) ? 1 : 0);
         check($sformatf("h_done%0d", k), 32'(done_b), 0);
         if (k == 2) req_b = 2'b00;
      end
      refill_valid_b = 1'b1;
      refill_item_b = STAR;
      refill_qty_b = 8'd5;
      tick();
      refill_valid_b = 1'b0;
      check("h_refill5", 32'(dut_b.star_stock), 5);
      check("h_empty_clr", 32'(empty_b), 0);
      // refill coincides with the CHECK decrement
      req_b = 2'b01;
      tick();
      refill_valid_b = 1'b1;
      refill_qty_b = 8'd3;
      tick();
      refill_valid_b = 1'b0;
      check("h_dec_refill", 32'(dut_b.star_stock), 7);
      check("h_motor_on", 32'(motor_en_b), 1);
      repeat (4) tick();
      check("h_done2", 32'(done_b), 1);
      req_b = 2'b00;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/dispense_arbiter.md
DISPENSE_ARBITER -- requirements
Module: dispense_arbiter

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 4: number of cycles motor_en is held per dispense (min 1).
REQ-002 SHALL have parameter COOL_CYCLES, default 2: idle cycles after each dispense before the next grant (min 0).
REQ-003 SHALL have parameter STOCK_INIT, default 10: reset value of both stock counters (0..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  2  per-kiosk dispense request (kiosk 0, kiosk 1); held until done or nack.
REQ-007 SHALL have port req_item  input  2  per-kiosk item select: 0 = star, 1 = straits; stable while req is high.
REQ-008 SHALL have port grant  output  2  one-hot, the kiosk currently owning the dispenser.
REQ-009 SHALL have port done  output  2  one-cycle pulse to the served kiosk when its dispense completes.
REQ-010 SHALL have port nack  output  2  one-cycle pulse to a kiosk whose selected item is out of stock.
REQ-011 SHALL have port motor_en  output  1  drive for the shared feed motor.
REQ-012 SHALL have port motor_sel  output  1  chute select: 0 = star, 1 = straits; valid while motor_en is high.
REQ-013 SHALL have port refill_valid  input  1  one-cycle refill strobe.
REQ-014 SHALL have port refill_item  input  1  item to refill: 0 = star, 1 = straits.
REQ-015 SHALL have port refill_qty  input  8  copies added on refill_valid.
REQ-016 SHALL have port empty  output  2  bit0 high when star stock is 0; bit1 high when straits stock is 0.

Function
REQ-017 SHALL implement the FSM states IDLE, CHECK, DISPENSE and COOL.
REQ-018 IDLE: when any req bit is high, SHALL pick the winner by round-robin pointer rr (rr = preferred kiosk), latch the winner id and its item, then go to CHECK.
REQ-019 Only one req high: that kiosk SHALL win regardless of rr.
REQ-020 CHECK, stock of latched item = 0: SHALL pulse nack[winner] for 1 cycle, set rr = ~winner, return to IDLE.
REQ-021 CHECK, stock > 0: SHALL decrement that stock by 1 and go to DISPENSE.
REQ-022 DISPENSE: grant[winner] = 1, motor_en = 1 and motor_sel = item SHALL hold for exactly MOTOR_CYCLES cycles.
REQ-023 On the cycle after the last motor cycle, SHALL pulse done[winner] for 1 cycle, drop grant, set rr = ~winner and enter COOL.
REQ-024 COOL SHALL last COOL_CYCLES cycles, then return to IDLE; COOL_CYCLES = 0 SHALL mean a direct return to IDLE.
REQ-025 Latency from req rising in IDLE to motor_en high SHALL be 2 cycles.
REQ-026 Deassertion of req during CHECK or DISPENSE SHALL be ignored; a motor cycle, once started, always completes.
REQ-027 Refill SHALL add refill_qty to the selected stock, saturating at 255; it is accepted in any state.
REQ-028 A refill and a decrement of the same item in the same cycle SHALL both apply: result = min(stock - 1 + qty, 255).
REQ-029 empty SHALL be combinational from the stock registers.
REQ-030 grant SHALL never have more than 1 bit set, and done and nack SHALL never be high in the same cycle.

Reset
REQ-031 While rst = 0, SHALL force: state = IDLE, rr = 0, grant = 0, done = 0, nack = 0, motor_en = 0, motor_sel = 0, both stocks = STOCK_INIT.
REQ-032 Reset asserted mid-DISPENSE SHALL drop motor_en immediately, without waiting for a clock edge; the aborted dispense SHALL NOT restore stock.

Structure
REQ-033 The state encoding, the item codes (STAR = 0, STRAITS = 1) and the stock width SHALL live in the shared package vend_pkg.
REQ-034 The per-item saturating stock counter SHALL be one sub-module, stock_counter, instantiated twice.

Verification
REQ-035 Reset, then req = 01 with item 0 -> motor_en high in cycles 2-5 with motor_sel = 0, done = 01 in cycle 6, star stock 10 -> 9.
REQ-036 req = 11 held continuously, items 0/1 -> grants alternate 01, 10, 01 with COOL gaps of 2 cycles; each done goes to the granted kiosk.
REQ-037 STOCK_INIT = 1, two star requests -> first request gets done; second gets a nack pulse with no motor_en; empty[0] = 1.
REQ-038 refill star with qty 250 at stock 9 -> stock 255 (saturated); refill coinciding with the CHECK decrement at stock 5, qty 3 -> stock 7.
REQ-039 rst low during the 3rd motor cycle -> motor_en low before the next edge; after release, state IDLE and both stocks = 10.
REQ-040 req dropped in the 1st DISPENSE cycle -> motor_en still held for 4 cycles and done still pulses.
